trivium_ctrl: RTL and testbench

Sequencer for a bit-serial Trivium core.
- Accepts an 80-bit key and an 80-bit IV byte-serially over a config handshake, then presents them to the core.
- Pulses the core load, runs the warm-up rounds, then advances the core 8 rounds per keystream byte.
- Packs the z bits into bytes and serves them on a valid/ready interface to the encrypt/FIFO stage.
- Enforces a per-key byte limit.

---
 rtl/trivium_pkg.sv | 23 ++
 rtl/trivium_byte_packer.sv | 41 ++++
 rtl/trivium_ctrl.sv | 176 +++++++++++++++++
 tb/tb_trivium_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium sequencer.
// Holds the controller state encoding, the key/IV byte counts, the default
// warm-up length (4 full passes over the 288-bit state) and the keystream
// byte width. No ports.
package trivium_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_IV,
    INIT,
    WARMUP,
    GEN,
    HOLD,
    EXHAUSTED
  } state_e;

  localparam int KEY_BYTES         = 10;
  localparam int IV_BYTES          = 10;
  localparam int DEF_WARMUP_ROUNDS = 1152;
  localparam int KS_BITS           = 8;

endpackage

// File: rtl/trivium_byte_packer.sv
// LSB-first serial-to-parallel packer for Trivium keystream bits.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr_i     - synchronous clear of shift register and bit counter
//   en_i      - shift in bit_i this cycle
//   bit_i     - keystream bit
//   byte_o    - byte including this cycle's bit (valid when done_o=1)
//   done_o    - this cycle's bit completes a byte
module trivium_byte_packer
  import trivium_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic               bit_i,
  output logic [KS_BITS-1:0] byte_o,
  output logic               done_o
);

  logic [KS_BITS-1:0] sr_q, sr_d;
  logic [2:0]         cnt_q;

  // Right shift: the first bit received ends up in bit 0 after eight shifts.
  assign sr_d   = {bit_i, sr_q[KS_BITS-1:1]};
  // Exposing the next value lets the caller capture the byte on the same
  // edge the last bit arrives, saving a cycle per byte.
  assign byte_o = sr_d;
  assign done_o = en_i && (cnt_q == 3'(KS_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      sr_q  <= sr_d;
      cnt_q <= cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/trivium_ctrl.sv
// Sequencer for a bit-serial Trivium core.
// Loads an 80-bit key and IV byte-serially, strobes the core load, runs the
// warm-up rounds, then clocks the core 8 rounds per keystream byte and serves
// bytes on a valid/ready port until MAX_BYTES have been taken.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cfg_start           - restart pulse (aborts anything in progress)
//   cfg_valid/cfg_data  - key bytes 0..9 then IV bytes 0..9
//   cfg_ready           - config byte accepted this cycle
//   key_out, iv_out     - assembled key/IV presented to the core
//   core_init, core_en  - core load strobe / advance-one-round
//   core_z              - core keystream bit
//   ks_valid/ks_byte/ks_ready - keystream byte handshake
//   busy                - loading, initialising or warming up
//   exhausted           - byte limit reached for this key/IV
module trivium_ctrl
  import trivium_pkg::*;
#(
  parameter int WARMUP_ROUNDS = DEF_WARMUP_ROUNDS,
  parameter int MAX_BYTES     = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic [7:0]   cfg_data,
  output logic         cfg_ready,
  output logic [79:0]  key_out,
  output logic [79:0]  iv_out,
  output logic         core_init,
  output logic         core_en,
  input  logic         core_z,
  output logic         ks_valid,
  output logic [7:0]   ks_byte,
  input  logic         ks_ready,
  output logic         busy,
  output logic         exhausted
);

  localparam int RW = $clog2(WARMUP_ROUNDS + 1);
  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int IW = $clog2(KEY_BYTES);

  state_e             state_q, state_d;
  logic [79:0]        key_q, key_d, iv_q, iv_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [RW-1:0]      rnd_q, rnd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [KS_BITS-1:0] ks_byte_q, ks_byte_d;
  logic [KS_BITS-1:0] pk_byte;
  logic               pk_en, pk_clr, pk_done;

  trivium_byte_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (pk_clr),
    .en_i   (pk_en),
    .bit_i  (core_z),
    .byte_o (pk_byte),
    .done_o (pk_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      iv_q      <= '0;
      idx_q     <= '0;
      rnd_q     <= '0;
      cnt_q     <= '0;
      ks_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      iv_q      <= iv_d;
      idx_q     <= idx_d;
      rnd_q     <= rnd_d;
      cnt_q     <= cnt_d;
      ks_byte_q <= ks_byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    iv_d      = iv_q;
    idx_d     = idx_q;
    rnd_d     = rnd_q;
    cnt_d     = cnt_q;
    ks_byte_d = ks_byte_q;
    cfg_ready = 1'b0;
    core_init = 1'b0;
    core_en   = 1'b0;
    ks_valid  = 1'b0;
    exhausted = 1'b0;
    pk_en     = 1'b0;
    pk_clr    = 1'b0;

    // A restart wins over every handshake in the same cycle; all outputs
    // that would otherwise be active this cycle are held low.
    if (cfg_start) begin
      state_d = LOAD_KEY;
      key_d   = '0;
      iv_d    = '0;
      idx_d   = '0;
      rnd_d   = '0;
      cnt_d   = '0;
      pk_clr  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD_KEY: begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            key_d[8*idx_q +: 8] = cfg_data;
            if (idx_q == IW'(KEY_BYTES - 1)) begin
              idx_d   = '0;
              state_d = LOAD_IV;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        LOAD_IV: begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            iv_d[8*idx_q +: 8] = cfg_data;
            if (idx_q == IW'(IV_BYTES - 1)) begin
              idx_d   = '0;
              state_d = INIT;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        INIT: begin
          core_init = 1'b1;
          state_d   = WARMUP;
        end
        WARMUP: begin
          core_en = 1'b1;
          if (rnd_q == RW'(WARMUP_ROUNDS - 1)) begin
            rnd_d   = '0;
            state_d = GEN;
          end else begin
            rnd_d = rnd_q + 1'b1;
          end
        end
        GEN: begin
          core_en = 1'b1;
          pk_en   = 1'b1;
          if (pk_done) begin
            ks_byte_d = pk_byte;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          ks_valid = 1'b1;
          if (ks_ready) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(MAX_BYTES - 1)) ? EXHAUSTED : GEN;
          end
        end
        EXHAUSTED: exhausted = 1'b1;
        default:   state_d = IDLE;
      endcase
    end
  end

  assign busy    = (state_q == LOAD_KEY) || (state_q == LOAD_IV) ||
                   (state_q == INIT) || (state_q == WARMUP);
  assign key_out = key_q;
  assign iv_out  = iv_q;
  assign ks_byte = ks_byte_q;

endmodule

// File: tb/tb_trivium_ctrl.sv
module tb_trivium_ctrl;

  localparam int WR = 1152;
  localparam int MB = 3;

  logic        clk, rst, cfg_start, cfg_valid, cfg_ready;
  logic [7:0]  cfg_data, ks_byte;
  logic [79:0] key_out, iv_out;
  logic        core_init, core_en, core_z, ks_valid, ks_ready, busy, exhausted;

  int checks = 0;
  int errors = 0;

  trivium_ctrl #(.WARMUP_ROUNDS(WR), .MAX_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .key_out(key_out),
    .iv_out(iv_out), .core_init(core_init), .core_en(core_en),
    .core_z(core_z), .ks_valid(ks_valid), .ks_byte(ks_byte),
    .ks_ready(ks_ready), .busy(busy), .exhausted(exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keystream bit source: a fresh bit every cycle, recorded by cycle number.
  // A fixed pattern can be injected for 8 cycles starting at pat_start.
  int         cyc = 0;
  int         pat_start = -100;
  logic [7:0] pat = 8'h8D;
  logic       zhist [0:16383];

  always begin
    logic zb;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= pat_start && cyc < pat_start + 8) zb = pat[cyc - pat_start];
    else zb = 1'($urandom_range(0, 1));
    core_z = zb;
    zhist[cyc & 16383] = zb;
  end

  logic [7:0] kb [10];
  logic [7:0] ib [10];

  // Byte produced by 8 consecutive generation cycles starting at g, LSB first.
  function automatic logic [7:0] model_byte(input int g);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = zhist[(g + k) & 16383];
    return b;
  endfunction

  function automatic logic [79:0] model_vec(input logic [7:0] v [10]);
    logic [79:0] r;
    for (int i = 0; i < 10; i++) r[8*i +: 8] = v[i];
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h5A; ks_ready = 1'b1;
    repeat (3) next_cycle();
    #1;
    checks++;
    if ({key_out, iv_out} !== 160'd0) begin
      errors++; $display("FAIL reset_keyiv: got %h expected 0", {key_out, iv_out});
    end
    checks++;
    if (ks_byte !== 8'h00) begin
      errors++; $display("FAIL reset_ksbyte: got %h expected 00", ks_byte);
    end
    checks++;
    if ({cfg_ready, core_init, core_en, ks_valid, busy, exhausted} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {cfg_ready, core_init, core_en, ks_valid, busy, exhausted});
    end
    next_cycle();
    rst = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b1; ks_ready = 1'b0;
    #1;
    checks++;
    if ({cfg_ready, busy} !== 2'b00) begin
      errors++; $display("FAIL idle_state: got %b expected 00", {cfg_ready, busy});
    end
    next_cycle();
    #1;
    checks++;
    if (key_out !== 80'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_ignore_cfg: got key %h busy %b expected 0/0", key_out, busy);
    end
    cfg_valid = 1'b0;
  endtask

  // cfg_start cycle (with a junk cfg byte offered), 20 bytes, then INIT.
  task automatic do_load(output int t_init);
    int inits, bad_rdy, bad_busy;
    logic [79:0] ek, ei;
    inits = 0; bad_rdy = 0; bad_busy = 0;
    next_cycle();
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hFF; ks_ready = 1'b0;
    #1;
    checks++;
    if ({cfg_ready, core_en, ks_valid, exhausted, core_init} !== 5'b0) begin
      errors++;
      $display("FAIL start_gating: got %b expected 00000",
               {cfg_ready, core_en, ks_valid, exhausted, core_init});
    end
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      cfg_start = 1'b0; cfg_valid = 1'b1;
      cfg_data = (i < 10) ? kb[i] : ib[i - 10];
      #1;
      if (i == 0) begin
        checks++;
        if ({key_out, iv_out} !== 160'd0) begin
          errors++; $display("FAIL start_clear: got %h expected 0", {key_out, iv_out});
        end
      end
      if (cfg_ready !== 1'b1) bad_rdy++;
      if (busy !== 1'b1) bad_busy++;
      if (core_init !== 1'b0) inits++;
    end
    next_cycle();
    cfg_valid = 1'b0;
    #1;
    t_init = cyc;
    ek = model_vec(kb);
    ei = model_vec(ib);
    checks++;
    if (bad_rdy != 0 || bad_busy != 0) begin
      errors++; $display("FAIL load_ready_busy: got %0d/%0d bad cycles expected 0/0", bad_rdy, bad_busy);
    end
    checks++;
    if (core_init !== 1'b1 || inits != 0 || core_en !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL init_pulse: got init %b early %0d en %b rdy %b expected 1 0 0 0",
               core_init, inits, core_en, cfg_ready);
    end
    checks++;
    if (key_out !== ek) begin
      errors++; $display("FAIL key_out: got %h expected %h", key_out, ek);
    end
    checks++;
    if (iv_out !== ei) begin
      errors++; $display("FAIL iv_out: got %h expected %h", iv_out, ei);
    end
  endtask

  task automatic test_warmup(input int t);
    int en_warm, bad_warm, bad_gen, bad_vld;
    en_warm = 0; bad_warm = 0; bad_gen = 0; bad_vld = 0;
    for (int c = 1; c <= WR + 8; c++) begin
      next_cycle();
      #1;
      if (c <= WR) begin
        if (core_en === 1'b1) en_warm++;
        if (core_init !== 1'b0 || busy !== 1'b1) bad_warm++;
      end else begin
        if (core_en !== 1'b1 || busy !== 1'b0 || core_init !== 1'b0) bad_gen++;
      end
      if (ks_valid !== 1'b0) bad_vld++;
    end
    checks++;
    if (en_warm != WR || bad_warm != 0) begin
      errors++; $display("FAIL warmup_en: got %0d en, %0d bad expected %0d, 0", en_warm, bad_warm, WR);
    end
    checks++;
    if (bad_gen != 0 || bad_vld != 0) begin
      errors++; $display("FAIL first_gen: got %0d/%0d bad cycles expected 0/0", bad_gen, bad_vld);
    end
    next_cycle();
    #1;
    checks++;
    if (ks_valid !== 1'b1 || core_en !== 1'b0 || cyc != t + WR + 9) begin
      errors++; $display("FAIL ks_valid_rise: got vld %b en %b expected 1 0", ks_valid, core_en);
    end
    checks++;
    if (ks_byte !== model_byte(t + WR + 1)) begin
      errors++; $display("FAIL first_byte: got %h expected %h", ks_byte, model_byte(t + WR + 1));
    end
  endtask

  task automatic test_backpressure(output int h);
    int bad;
    logic [7:0] b0;
    bad = 0;
    b0 = ks_byte;
    for (int i = 0; i < 50; i++) begin
      next_cycle();
      ks_ready = 1'b0;
      #1;
      if (ks_valid !== 1'b1 || ks_byte !== b0 || core_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
    end
    next_cycle();
    ks_ready = 1'b1;
    #1;
    h = cyc;
    checks++;
    if (ks_valid !== 1'b1 || ks_byte !== b0) begin
      errors++; $display("FAIL hold_release: got vld %b byte %h expected 1 %h", ks_valid, ks_byte, b0);
    end
  endtask

  // After a handshake at cycle h, expect n further bytes at 9-cycle spacing.
  task automatic test_stream(input int h, input int n);
    int bad, g;
    logic [7:0] exp_b;
    for (int b = 0; b < n; b++) begin
      bad = 0;
      g = h + 1;
      for (int k = 0; k < 8; k++) begin
        next_cycle();
        #1;
        if (core_en !== 1'b1 || ks_valid !== 1'b0) bad++;
      end
      next_cycle();
      #1;
      exp_b = model_byte(g);
      checks++;
      if (bad != 0 || ks_valid !== 1'b1 || ks_byte !== exp_b) begin
        errors++;
        $display("FAIL stream_byte%0d: got vld %b byte %h (%0d bad gen) expected 1 %h",
                 b, ks_valid, ks_byte, bad, exp_b);
      end
      h = cyc;
    end
  endtask

  task automatic test_exhausted();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      ks_ready = 1'b0; cfg_valid = 1'b1; cfg_data = 8'($urandom);
      #1;
      if (exhausted !== 1'b1 || core_en !== 1'b0 || ks_valid !== 1'b0 ||
          busy !== 1'b0 || cfg_ready !== 1'b0 || core_init !== 1'b0) bad++;
    end
    cfg_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL exhausted_state: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_abort_warmup();
    int bad;
    bad = 0;
    for (int c = 1; c < 5; c++) begin
      next_cycle();
      #1;
      if (core_en !== 1'b1) bad++;
    end
    next_cycle();
    cfg_start = 1'b1;
    #1;
    checks++;
    if (core_en !== 1'b0 || bad != 0) begin
      errors++; $display("FAIL abort_gate: got en %b (%0d bad) expected 0", core_en, bad);
    end
    bad = 0;
    for (int i = 0; i < WR + 150; i++) begin
      next_cycle();
      cfg_start = 1'b0;
      #1;
      if (core_init !== 1'b0 || ks_valid !== 1'b0 || core_en !== 1'b0 ||
          busy !== 1'b1 || cfg_ready !== 1'b1 || key_out !== 80'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL abort_quiet: got %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    int t, h;
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00; ks_ready = 1'b0;

    test_reset();

    // Fixed key/IV, fixed first byte pattern, backpressure, limit.
    for (int i = 0; i < 10; i++) begin
      kb[i] = 8'(i);
      ib[i] = 8'(8'hA0 + i);
    end
    do_load(t);
    checks++;
    if (key_out !== 80'h09080706050403020100 || iv_out !== 80'hA9A8A7A6A5A4A3A2A1A0) begin
      errors++; $display("FAIL keyiv_const: got %h %h", key_out, iv_out);
    end
    pat_start = t + WR + 1;
    test_warmup(t);
    checks++;
    if (ks_byte !== 8'h8D) begin
      errors++; $display("FAIL pack_pattern: got %h expected 8d", ks_byte);
    end
    test_backpressure(h);
    test_stream(h, MB - 1);
    test_exhausted();

    // Restart out of EXHAUSTED, then abort during warm-up.
    for (int i = 0; i < 10; i++) begin
      kb[i] = 8'($urandom);
      ib[i] = 8'($urandom);
    end
    do_load(t);
    test_abort_warmup();

    // Restart from LOAD_KEY; byte counter must start afresh.
    for (int i = 0; i < 10; i++) begin
      kb[i] = 8'($urandom);
      ib[i] = 8'($urandom);
    end
    do_load(t);
    test_warmup(t);
    ks_ready = 1'b1;
    test_stream(cyc, MB - 1);
    test_exhausted();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
